// File: rtl/cgra_run_controller_if.sv
// Host-side job handshake bundle for cgra_run_controller.
// With CGRA_RUN_CTRL_PERF_EN defined the bundle also carries the
// cfg_cycles/job_cycles performance counters.
interface cgra_run_controller_if #(
  parameter int unsigned RUN_CNT_W = 32
);
  logic                 start;
  logic [RUN_CNT_W-1:0] run_cycles;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [2:0]           state;
`ifdef CGRA_RUN_CTRL_PERF_EN
  logic [31:0]          cfg_cycles;
  logic [31:0]          job_cycles;

  modport master (
    output start, run_cycles, abort,
    input  busy, done, error, state, cfg_cycles, job_cycles
  );
  modport slave (
    input  start, run_cycles, abort,
    output busy, done, error, state, cfg_cycles, job_cycles
  );
`else
  modport master (
    output start, run_cycles, abort,
    input  busy, done, error, state
  );
  modport slave (
    input  start, run_cycles, abort,
    output busy, done, error, state
  );
`endif
endinterface

// File: rtl/cgra_run_controller.sv
// Sequences one CGRA job: configurator reset, bitstream load with timeout,
// a settle cycle that stops the Config clock, CGRA reset, then a counted run.
// Optional macro CGRA_RUN_CTRL_PERF_EN adds cfg_cycles/job_cycles counters.
module cgra_run_controller #(
  parameter int unsigned RUN_CNT_W    = 32,
  parameter int unsigned CFG_TIMEOUT  = 65536,
  parameter int unsigned RESET_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cgra_run_controller_if.slave  host,
  input  logic                  configurator_done,
  output logic                  config_clock_en,
  output logic                  config_reset,
  output logic                  configurator_reset,
  output logic                  configurator_enable,
  output logic                  cgra_clock_en,
  output logic                  cgra_reset,
  output logic                  cgra_enable
);

  localparam int unsigned TO_W  = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT) : 1;
  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CFG_TIMEOUT - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_RST  = 3'd1,
    S_CONFIG   = 3'd2,
    S_SETTLE   = 3'd3,
    S_CGRA_RST = 3'd4,
    S_RUN      = 3'd5,
    S_FIN      = 3'd6,
    S_ERR      = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                 error_q, error_d;

  logic config_clock_en_q, config_clock_en_d;
  logic config_reset_q, config_reset_d;
  logic configurator_reset_q, configurator_reset_d;
  logic configurator_enable_q, configurator_enable_d;
  logic cgra_clock_en_q, cgra_clock_en_d;
  logic cgra_reset_q, cgra_reset_d;
  logic cgra_enable_q, cgra_enable_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state, phase counters and sticky error; abort overrides every transition.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    to_cnt_d  = to_cnt_q;
    rst_cnt_d = rst_cnt_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          state_d   = S_CFG_RST;
          run_cnt_d = host.run_cycles;
          error_d   = 1'b0;
        end
      end
      S_CFG_RST: begin
        state_d  = S_CONFIG;
        to_cnt_d = '0;
      end
      S_CONFIG: begin
        if (configurator_done) begin
          state_d = S_SETTLE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_SETTLE: begin
        state_d   = S_CGRA_RST;
        rst_cnt_d = '0;
      end
      S_CGRA_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = (run_cnt_q == '0) ? S_FIN : S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_RUN: begin
        if (run_cnt_q == RUN_CNT_W'(1)) begin
          state_d = S_FIN;
        end else begin
          run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && host.abort) begin
      state_d = S_IDLE;
    end
    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end
  end

  // Moore decode of the upcoming state so registered outputs line up with state_q.
  always_comb begin
    config_clock_en_d     = 1'b0;
    config_reset_d        = 1'b0;
    configurator_reset_d  = 1'b0;
    configurator_enable_d = 1'b0;
    cgra_clock_en_d       = 1'b0;
    cgra_reset_d          = 1'b0;
    cgra_enable_d         = 1'b0;
    done_d                = 1'b0;
    busy_d                = (state_d != S_IDLE);
    case (state_d)
      S_CFG_RST: begin
        config_clock_en_d    = 1'b1;
        config_reset_d       = 1'b1;
        configurator_reset_d = 1'b1;
      end
      S_CONFIG: begin
        config_clock_en_d     = 1'b1;
        configurator_enable_d = 1'b1;
      end
      S_CGRA_RST: begin
        cgra_clock_en_d = 1'b1;
        cgra_enable_d   = 1'b1;
        cgra_reset_d    = 1'b1;
      end
      S_RUN: begin
        cgra_clock_en_d = 1'b1;
        cgra_enable_d   = 1'b1;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= S_IDLE;
      run_cnt_q             <= '0;
      to_cnt_q              <= '0;
      rst_cnt_q             <= '0;
      error_q               <= 1'b0;
      config_clock_en_q     <= 1'b0;
      config_reset_q        <= 1'b0;
      configurator_reset_q  <= 1'b0;
      configurator_enable_q <= 1'b0;
      cgra_clock_en_q       <= 1'b0;
      cgra_reset_q          <= 1'b0;
      cgra_enable_q         <= 1'b0;
      busy_q                <= 1'b0;
      done_q                <= 1'b0;
    end else begin
      state_q               <= state_d;
      run_cnt_q             <= run_cnt_d;
      to_cnt_q              <= to_cnt_d;
      rst_cnt_q             <= rst_cnt_d;
      error_q               <= error_d;
      config_clock_en_q     <= config_clock_en_d;
      config_reset_q        <= config_reset_d;
      configurator_reset_q  <= configurator_reset_d;
      configurator_enable_q <= configurator_enable_d;
      cgra_clock_en_q       <= cgra_clock_en_d;
      cgra_reset_q          <= cgra_reset_d;
      cgra_enable_q         <= cgra_enable_d;
      busy_q                <= busy_d;
      done_q                <= done_d;
    end
  end

  assign config_clock_en     = config_clock_en_q;
  assign config_reset        = config_reset_q;
  assign configurator_reset  = configurator_reset_q;
  assign configurator_enable = configurator_enable_q;
  assign cgra_clock_en       = cgra_clock_en_q;
  assign cgra_reset          = cgra_reset_q;
  assign cgra_enable         = cgra_enable_q;
  assign host.busy           = busy_q;
  assign host.done           = done_q;
  assign host.error          = error_q;
  assign host.state          = state_q;

`ifdef CGRA_RUN_CTRL_PERF_EN
  logic [31:0] cfg_cycles_q, cfg_cycles_d;
  logic [31:0] job_cycles_q, job_cycles_d;

  // Counters restart on an accepted start and hold once the job leaves busy states.
  always_comb begin
    cfg_cycles_d = cfg_cycles_q;
    job_cycles_d = job_cycles_q;
    if (state_q == S_IDLE) begin
      if (host.start) begin
        cfg_cycles_d = '0;
        job_cycles_d = '0;
      end
    end else begin
      job_cycles_d = job_cycles_q + 32'd1;
      if (state_q == S_CONFIG) begin
        cfg_cycles_d = cfg_cycles_q + 32'd1;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_cycles_q <= '0;
      job_cycles_q <= '0;
    end else begin
      cfg_cycles_q <= cfg_cycles_d;
      job_cycles_q <= job_cycles_d;
    end
  end

  assign host.cfg_cycles = cfg_cycles_q;
  assign host.job_cycles = job_cycles_q;
`endif

endmodule

// File: tb/tb_cgra_run_controller.sv
// Self-checking bench for cgra_run_controller: directed plus random jobs,
// each checked cycle by cycle against a phase-length model of the job.
module tb_cgra_run_controller;

  localparam int unsigned RUN_W   = 32;
  localparam int          CFG_TO  = 48;
  localparam int          RST_CYC = 1;

  logic clock;
  logic reset_n;
  logic configurator_done;
  logic config_clock_en, config_reset, configurator_reset, configurator_enable;
  logic cgra_clock_en, cgra_reset, cgra_enable;

  int tests;
  int fails;
  int job_id;

  cgra_run_controller_if #(.RUN_CNT_W(RUN_W)) host_if ();

  cgra_run_controller #(
    .RUN_CNT_W   (RUN_W),
    .CFG_TIMEOUT (CFG_TO),
    .RESET_CYCLES(RST_CYC)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .host               (host_if),
    .configurator_done  (configurator_done),
    .config_clock_en    (config_clock_en),
    .config_reset       (config_reset),
    .configurator_reset (configurator_reset),
    .configurator_enable(configurator_enable),
    .cgra_clock_en      (cgra_clock_en),
    .cgra_reset         (cgra_reset),
    .cgra_enable        (cgra_enable)
  );

  logic [12:0] obs;
  assign obs = {config_clock_en, config_reset, configurator_reset, configurator_enable,
                cgra_clock_en, cgra_reset, cgra_enable,
                host_if.busy, host_if.done, host_if.error, host_if.state};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Phase of busy cycle c for a job with cfg CONFIG cycles, timeout flag and run length n.
  function automatic int exp_phase(input int c, input int cfg, input bit to, input int n);
    if (c == 0) return 1;
    if (c <= cfg) return 2;
    if (c == cfg + 1) return to ? 7 : 3;
    if (to) return 0;
    if (c < cfg + 2 + RST_CYC) return 4;
    if (c < cfg + 2 + RST_CYC + n) return 5;
    if (c == cfg + 2 + RST_CYC + n) return 6;
    return 0;
  endfunction

  // Pin values the controller is required to show in each phase.
  function automatic logic [12:0] exp_vec(input int p, input bit err);
    logic cce, crst, crrst, cen, gce, grst, gen, dn;
    {cce, crst, crrst, cen, gce, grst, gen, dn} = 8'b0;
    case (p)
      1: begin cce = 1'b1; crst = 1'b1; crrst = 1'b1; end
      2: begin cce = 1'b1; cen = 1'b1; end
      4: begin gce = 1'b1; grst = 1'b1; gen = 1'b1; end
      5: begin gce = 1'b1; gen = 1'b1; end
      6: dn = 1'b1;
      default: ;
    endcase
    return {cce, crst, crrst, cen, gce, grst, gen, (p != 0), dn, err, 3'(p)};
  endfunction

  // k: configurator finishes after k enabled cycles (1 = already high, 0 = never).
  // abort_at/start_at: busy-cycle index for a pulse; -1 none, -2 random.
  task automatic run_job(input int k, input int n, input int abort_at_i, input int start_at_i,
                         input bit abort_with_start);
    bit   to, ended;
    int   cfg, total, exp_busy, p, abort_at, start_at, cfg_seen;
    int   busy_n, run_n, grst_n, cclk_n, done_n, first_run, viol;
    int   e_run, e_grst, e_cclk, e_done, e_first;
    logic [12:0] ev;
    to    = !(k >= 1 && k <= CFG_TO);
    cfg   = to ? CFG_TO : k;
    total = to ? cfg + 2 : cfg + 3 + RST_CYC + n;
    abort_at = abort_at_i;
    start_at = start_at_i;
    if (abort_at == -2) abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 2)) : -1;
    if (start_at == -2) start_at = int'($urandom_range(0, total - 1));
    exp_busy = (abort_at >= 0 && abort_at < total) ? abort_at + 1 : total;
    {e_run, e_grst, e_cclk, e_done} = '0;
    for (int c = 0; c < exp_busy; c++) begin
      p = exp_phase(c, cfg, to, n);
      if (p == 5) e_run++;
      if (p == 4) e_grst++;
      if (p == 1 || p == 2) e_cclk++;
      if (p == 6) e_done++;
    end
    e_first = (e_run > 0) ? cfg + 2 + RST_CYC : -1;
    job_id++;
    {busy_n, run_n, grst_n, cclk_n, done_n, viol, cfg_seen} = '0;
    first_run = -1;
    ended = 1'b0;
    host_if.start      = 1'b1;
    host_if.run_cycles = RUN_W'(n);
    host_if.abort      = abort_with_start;
    configurator_done  = (k == 1);
    @(negedge clock);
    host_if.start = 1'b0;
    host_if.abort = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!host_if.busy) begin
        ended = 1'b1;
        break;
      end
      busy_n++;
      ev = exp_vec(exp_phase(cyc, cfg, to, n), to && cyc >= cfg + 1);
      if (cyc < exp_busy && obs !== ev) begin
        viol++;
        if (viol == 1) $display("[TB] job %0d cycle %0d pins %b want %b", job_id, cyc, obs, ev);
      end
      if (cgra_enable && !cgra_reset) begin
        run_n++;
        if (first_run < 0) first_run = cyc;
      end
      if (cgra_reset) grst_n++;
      if (config_clock_en) cclk_n++;
      if (host_if.done) done_n++;
      if (configurator_enable) cfg_seen++;
      configurator_done = (k == 1) || (k >= 1 && cfg_seen >= k);
      host_if.abort = (cyc == abort_at);
      host_if.start = (cyc == start_at);
      if (cyc == start_at) host_if.run_cycles = $urandom;
      @(negedge clock);
    end
    host_if.start = 1'b0;
    host_if.abort = 1'b0;
    configurator_done = 1'b0;
    if (!ended) check_eq("job_end_bound", 0, 1);
    check_eq("busy_cycles", busy_n, exp_busy);
    check_eq("pin_trace_mismatches", viol, 0);
    check_eq("run_cycles_seen", run_n, e_run);
    check_eq("cgra_reset_cycles", grst_n, e_grst);
    check_eq("config_clk_cycles", cclk_n, e_cclk);
    check_eq("done_pulses", done_n, e_done);
    check_eq("first_run_index", first_run, e_first);
    check_eq("error_after_job", host_if.error, (to && exp_busy == total) ? 1 : 0);
`ifdef CGRA_RUN_CTRL_PERF_EN
    if (!to && exp_busy == total) begin
      check_eq("perf_cfg_cycles", host_if.cfg_cycles, cfg);
      check_eq("perf_job_cycles", host_if.job_cycles, total);
    end
`endif
    @(negedge clock);
    check_eq("stays_idle", {host_if.busy, host_if.done}, 0);
  endtask

  // Async reset pulse in the middle of a 500-cycle run.
  task automatic reset_mid_run();
    int cfg_seen, run_seen, quiet;
    cfg_seen = 0;
    run_seen = 0;
    quiet    = 0;
    host_if.start      = 1'b1;
    host_if.run_cycles = RUN_W'(500);
    configurator_done  = 1'b0;
    @(negedge clock);
    host_if.start = 1'b0;
    for (int cyc = 0; cyc < 2000 && run_seen < 100; cyc++) begin
      if (configurator_enable) cfg_seen++;
      configurator_done = (cfg_seen >= 5);
      if (cgra_enable && !cgra_reset) run_seen++;
      if (run_seen < 100) @(negedge clock);
    end
    check_eq("rst_reached_run", run_seen, 100);
    check_eq("rst_pre_state", host_if.state, 5);
    #2 reset_n = 1'b0;
    #1 check_eq("async_rst_pins", obs, 0);
    @(negedge clock);
    reset_n = 1'b1;
    configurator_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (host_if.done || host_if.busy) quiet++;
      @(negedge clock);
    end
    check_eq("post_rst_quiet", quiet, 0);
  endtask

  initial begin
    int k, n, sel;
    tests  = 0;
    fails  = 0;
    job_id = 0;
    reset_n = 1'b0;
    host_if.start      = 1'b0;
    host_if.abort      = 1'b0;
    host_if.run_cycles = '0;
    configurator_done  = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("reset_pins", obs, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("idle_after_reset", obs, 0);

    run_job(40, 500, -1, -1, 1'b0);
    run_job(0, 7, -1, -1, 1'b0);
    host_if.abort = 1'b1;
    repeat (3) @(negedge clock);
    host_if.abort = 1'b0;
    check_eq("idle_abort_no_effect", {host_if.busy, host_if.error, host_if.state}, 16'b1_000);
    run_job(3, 2, -1, -1, 1'b0);
    run_job(5, 0, -1, -1, 1'b0);
    run_job(4, 50, 4 + 2 + RST_CYC + 10, 4 + 2 + RST_CYC + 3, 1'b0);
    run_job(1, 3, -1, -1, 1'b0);
    run_job(CFG_TO, 2, -1, -1, 1'b0);
    run_job(CFG_TO + 1, 2, -1, -1, 1'b0);
    run_job(6, 4, -1, -1, 1'b1);
    run_job(2, 1, -1, -1, 1'b0);

    for (int j = 0; j < 25; j++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       k = 0;
        1:       k = 1;
        2:       k = CFG_TO;
        3:       k = CFG_TO + int'($urandom_range(1, 3));
        default: k = int'($urandom_range(2, CFG_TO - 1));
      endcase
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 40));
      run_job(k, n, -2, -2, 1'($urandom_range(0, 1)));
    end

    reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_time_bound: got 1 expected 0");
    $fatal(1, "time bound exceeded");
  end

endmodule

// File: doc/cgra_run_controller.md
Name: cgra_run_controller

Overview:
- Sequences one complete CGRA job: drives the bitstream configurator and the Config clock gate, then resets the CGRA fabric, enables it and runs it for a programmed number of cycles.
- Replaces the hand-written configure/reset/run phase sequencing in benches and gives SoC integration one start/done handshake.
- Sits between the host/bench and the CGRA_configurator plus cgra_U0 control pins (Config_Clock gate, Config_Reset, CGRA_Clock gate, CGRA_Reset, CGRA_Enable).

Parameters:
- RUN_CNT_W, 32, width of run_cycles and the run counter.
- CFG_TIMEOUT, 65536, maximum CONFIG-state cycles allowed before configurator_done must rise (minimum 1).
- RESET_CYCLES, 1, cycles CGRA_Reset is held high with the CGRA clock running (minimum 1).

Ports:
- clock  in  1  single clock; the CGRA and Config clocks are derived from it via the *_clock_en gates.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- run_cycles  in  RUN_CNT_W  CGRA run length; captured on the accepted start.
- abort  in  1  terminates any active job.
- configurator_done  in  1  done output from CGRA_configurator.
- config_clock_en  out  1  Config_Clock gate.
- config_reset  out  1  drives the CGRA Config_Reset pin.
- configurator_reset  out  1  configurator sync_reset.
- configurator_enable  out  1  configurator enable.
- cgra_clock_en  out  1  CGRA_Clock and RAM clock gate.
- cgra_reset  out  1  CGRA_Reset.
- cgra_enable  out  1  CGRA_Enable.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky configuration-timeout flag.
- state  out  3  current state encoding, for debug.

Behaviour:
- reset_n low forces, asynchronously: state=IDLE, all outputs 0, counters 0, error 0.
- All outputs are registered Moore decodes of state; no combinational input-to-output paths.

State encodings and transitions:
- IDLE=0. start=1 → CFG_RST, capturing run_cycles; error clears on this transition.
- CFG_RST=1. Lasts 1 cycle. config_reset=1, configurator_reset=1, config_clock_en=1. Next state: CONFIG.
- CONFIG=2. configurator_enable=1, config_clock_en=1, timeout counter increments each cycle.
  - configurator_done=1 → SETTLE.
  - Else, if the counter reaches CFG_TIMEOUT-1 → ERR.
  - If done and timeout coincide, done wins.
- SETTLE=3. Lasts 1 cycle with all outputs low; freezes the Config clock before the CGRA clock starts. Next state: CGRA_RST.
- CGRA_RST=4. Lasts RESET_CYCLES cycles. cgra_clock_en=1, cgra_enable=1, cgra_reset=1.
  - Captured run_cycles==0 → FIN.
  - Else → RUN.
- RUN=5. cgra_clock_en=1, cgra_enable=1, cgra_reset=0.
  - Stays exactly run_cycles cycles, counted down to 1, then → FIN.
  - Maximum run length: 2^RUN_CNT_W-1 cycles.
- FIN=6. Lasts 1 cycle. done=1, CGRA gates off. Next state: IDLE.
- ERR=7. Lasts 1 cycle. error set, all gates off. Next state: IDLE.

Boundary conditions:
- abort=1 in any non-IDLE state → IDLE next cycle: all gates off, no done pulse, error unchanged. abort has priority over every other transition.
- abort in IDLE has no effect.
- start while busy is ignored and not queued. start and abort asserted together in IDLE: start is accepted.
- configurator_done already high on CONFIG entry → SETTLE after exactly 1 CONFIG cycle.
- Latency from start (IDLE) to the first RUN cycle: 1 (CFG_RST) + k (CONFIG) + 1 (SETTLE) + RESET_CYCLES. Here k is the number of CONFIG cycles, at least 1.
- busy falls the same cycle state returns to IDLE.

Optional Feature:
- Macro: CGRA_RUN_CTRL_PERF_EN.
- Defined: adds two outputs, both held after completion until the next accepted start or reset.
  - cfg_cycles (32 bit): CONFIG cycle count.
  - job_cycles (32 bit): cycles from CFG_RST through FIN inclusive.
- Undefined: these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- reset_n pulsed low mid-RUN (run_cycles=500, cycle 100 of RUN) → all outputs 0 asynchronously, state=0, done never pulses.
- start with run_cycles=500; configurator_done rises after 40 CONFIG cycles; RESET_CYCLES=1 → exactly 40 config_clock_en cycles in CONFIG plus 1 in CFG_RST; 1 cgra_reset cycle; 500 cycles with cgra_enable=1 and cgra_reset=0; one done pulse; busy low afterwards.
- configurator_done held low, CFG_TIMEOUT=16 → 16 CONFIG cycles, ERR, error=1, no done pulse, no cgra_clock_en. The next start clears error.
- run_cycles=0 → CGRA_RST goes directly to FIN; 0 RUN cycles; done pulses once.
- abort at RUN cycle 10, with start also pulsed during RUN → IDLE next cycle; CGRA gates off; no done; the mid-job start is ignored; error unchanged.
- CGRA_RUN_CTRL_PERF_EN defined, done after 40 CONFIG cycles, run_cycles=500, RESET_CYCLES=1 → cfg_cycles=40, job_cycles=544 (1+40+1+1+500+1).
